// File: rtl/ov5640_cap_pkg.sv
// Shared types and helpers for the OV5640 DVP pixel-capture stage.
package ov5640_cap_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT,
    SKIP,
    RUN
  } cap_state_e;

  localparam int COORD_W = 12;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  // RGB565 as the sensor delivers it: first byte = R[4:0],G[5:3]; second = G[2:0],B[4:0].
  typedef struct packed {
    logic [4:0] r;  // [15:11]
    logic [5:0] g;  // [10:5]
    logic [4:0] b;  // [4:0]
  } rgb565_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single slow level crossing into the local clock.
module cdc_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so the second flop samples the first flop's pre-edge value.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: skips settling frames after config, then packs byte pairs
// into RGB565 pixels with coordinates, frame-done and geometry-error status.
module ov5640_capture
  import ov5640_cap_pkg::*;
#(
  parameter int WAIT_FRAME   = 10,
  parameter int CMOS_H_PIXEL = 1024,
  parameter int CMOS_V_PIXEL = 768
) (
  input  logic               cam_pclk,
  input  logic               rst,
  input  logic               cam_init_done,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_data,
  output logic               cmos_frame_vsync,
  output logic               cmos_frame_href,
  output logic               cmos_frame_valid,
  output logic [15:0]        cmos_frame_data,
  output logic [COORD_W-1:0] cmos_pix_x,
  output logic [COORD_W-1:0] cmos_pix_y,
  output logic               cmos_frame_done,
  output logic               cmos_size_err
);

  localparam logic [3:0]         SKIP_LAST = 4'(WAIT_FRAME - 1);
  localparam logic [COORD_W-1:0] H_PIX     = COORD_W'(CMOS_H_PIXEL);
  localparam logic [COORD_W-1:0] V_PIX     = COORD_W'(CMOS_V_PIXEL);

  logic init_sync;

  cdc_sync_bit u_init_sync (
    .clk (cam_pclk),
    .rst (rst),
    .d_i (cam_init_done),
    .q_o (init_sync)
  );

  logic       vsync_d0_q, vsync_d1_q, href_d0_q, href_d1_q;
  logic [7:0] data_d0_q;
  logic       vs_rise, href_fall;

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      vsync_d0_q <= 1'b0;
      vsync_d1_q <= 1'b0;
      href_d0_q  <= 1'b0;
      href_d1_q  <= 1'b0;
      data_d0_q  <= '0;
    end else begin
      vsync_d0_q <= cam_vsync;
      vsync_d1_q <= vsync_d0_q;
      href_d0_q  <= cam_href;
      href_d1_q  <= href_d0_q;
      data_d0_q  <= cam_data;
    end
  end

  assign vs_rise   = vsync_d0_q & ~vsync_d1_q;
  assign href_fall = href_d1_q & ~href_d0_q;

  cap_state_e state_q, state_d;
  logic [3:0] skip_cnt_q, skip_cnt_d;
  logic       frame_ok_q, frame_ok_d;

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_INIT;
      skip_cnt_q <= '0;
      frame_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      frame_ok_q <= frame_ok_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    frame_ok_d = frame_ok_q;
    if (!init_sync) begin
      state_d    = WAIT_INIT;
      skip_cnt_d = '0;
      frame_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_INIT: state_d = SKIP;
        SKIP: begin
          if (vs_rise) begin
            if (skip_cnt_q == SKIP_LAST) begin
              state_d    = RUN;
              skip_cnt_d = '0;
              frame_ok_d = 1'b1;  // armed on a boundary, so no partial frame leaks out
            end else begin
              skip_cnt_d = skip_cnt_q + 4'd1;
            end
          end
        end
        RUN:     frame_ok_d = 1'b1;
        default: state_d = WAIT_INIT;
      endcase
    end
  end

  logic               run;
  logic               byte_flag_q, err_pend_q;
  logic [7:0]         hi_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               valid_q, done_q, size_err_q;
  rgb565_t            pix;
  logic [15:0]        data_q;
  logic [COORD_W-1:0] pix_x_q, pix_y_q;

  assign run = (state_q == RUN) && init_sync;
  assign pix = {hi_q, data_d0_q};

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      byte_flag_q <= 1'b0;
      err_pend_q  <= 1'b0;
      hi_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      size_err_q  <= 1'b0;
      data_q      <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (!run) begin
        byte_flag_q <= 1'b0;
        err_pend_q  <= 1'b0;
        x_q         <= '0;
        y_q         <= '0;
      end else if (vs_rise) begin
        // Frame boundary outranks any byte in flight on the same edge.
        byte_flag_q <= 1'b0;
        x_q         <= '0;
        y_q         <= '0;
        if (y_q != '0) begin
          done_q     <= 1'b1;
          size_err_q <= err_pend_q | (y_q != V_PIX);
          err_pend_q <= 1'b0;
        end
      end else if (href_d0_q) begin
        byte_flag_q <= ~byte_flag_q;
        if (!byte_flag_q) begin
          hi_q <= data_d0_q;
        end else begin
          valid_q <= 1'b1;
          data_q  <= pix;
          pix_x_q <= x_q;
          pix_y_q <= y_q;
          x_q     <= sat_inc(x_q);
        end
      end else begin
        byte_flag_q <= 1'b0;
        if (href_fall) begin
          x_q <= '0;
          if (x_q != '0) y_q <= sat_inc(y_q);
          if ((x_q != H_PIX) || byte_flag_q) err_pend_q <= 1'b1;
        end
      end
    end
  end

  assign cmos_frame_vsync = frame_ok_q & vsync_d1_q;
  assign cmos_frame_href  = frame_ok_q & href_d1_q;
  assign cmos_frame_valid = valid_q;
  assign cmos_frame_data  = data_q;
  assign cmos_pix_x       = pix_x_q;
  assign cmos_pix_y       = pix_y_q;
  assign cmos_frame_done  = done_q;
  assign cmos_size_err    = size_err_q;

endmodule

// File: tb/tb_ov5640_capture.sv
// Scoreboard bench: the driver pushes expected pixels/frame status from a
// frame-level model; an independent monitor pops and compares DUT output.
module tb_ov5640_capture;
  import ov5640_cap_pkg::*;

  localparam int WF = 2;
  localparam int H  = 4;
  localparam int V  = 2;

  logic        cam_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cam_init_done = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        cmos_frame_vsync, cmos_frame_href, cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic [11:0] cmos_pix_x, cmos_pix_y;
  logic        cmos_frame_done, cmos_size_err;

  always #5 cam_pclk = ~cam_pclk;

  ov5640_capture #(
    .WAIT_FRAME   (WF),
    .CMOS_H_PIXEL (H),
    .CMOS_V_PIXEL (V)
  ) dut (
    .cam_pclk         (cam_pclk),
    .rst              (rst),
    .cam_init_done    (cam_init_done),
    .cam_vsync        (cam_vsync),
    .cam_href         (cam_href),
    .cam_data         (cam_data),
    .cmos_frame_vsync (cmos_frame_vsync),
    .cmos_frame_href  (cmos_frame_href),
    .cmos_frame_valid (cmos_frame_valid),
    .cmos_frame_data  (cmos_frame_data),
    .cmos_pix_x       (cmos_pix_x),
    .cmos_pix_y       (cmos_pix_y),
    .cmos_frame_done  (cmos_frame_done),
    .cmos_size_err    (cmos_size_err)
  );

  typedef struct {
    logic [15:0] data;
    int          x;
    int          y;
    int          cyc;
  } pix_t;

  pix_t pix_q[$];
  bit   done_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   skip_left = 99;   // frames still to be discarded; large = not initialised
  int   m_y = 0;          // rows with at least one pixel in the current frame
  bit   m_err = 1'b0;     // pending geometry error carried to the next done
  bit   use_f81f = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge cam_pclk) cyc++;

  always @(posedge cam_pclk) begin : monitor
    pix_t e;
    bit   de;
    #1;
    if (cmos_frame_valid) begin
      if (pix_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = pix_q.pop_front();
        check("pix_data", cmos_frame_data, e.data);
        check("pix_x", cmos_pix_x, e.x);
        check("pix_y", cmos_pix_y, e.y);
        check("pix_latency", cyc, e.cyc);
      end
    end
    if (cmos_frame_done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        de = done_q.pop_front();
        check("size_err", cmos_size_err, de);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, cmos_frame_valid, 0);
    check({tag, "_data"},  cmos_frame_data, 0);
    check({tag, "_x"},     cmos_pix_x, 0);
    check({tag, "_y"},     cmos_pix_y, 0);
    check({tag, "_vsync"}, cmos_frame_vsync, 0);
    check({tag, "_href"},  cmos_frame_href, 0);
    check({tag, "_done"},  cmos_frame_done, 0);
    check({tag, "_err"},   cmos_size_err, 0);
  endtask

  task automatic start_init();
    cam_init_done = 1'b1;
    repeat (5) @(negedge cam_pclk);
    skip_left = WF;
    m_err     = 1'b0;
  endtask

  task automatic send_line(input int nbytes, input bit deliver);
    logic [7:0] hi;
    hi = '0;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge cam_pclk);
      if (i == 2) check("href_gate", cmos_frame_href, deliver);
      cam_href = 1'b1;
      cam_data = (use_f81f && i < 2) ? ((i == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
      if (i % 2 == 0) hi = cam_data;
      else if (deliver)
        pix_q.push_back('{data: {hi, cam_data}, x: i / 2, y: m_y, cyc: cyc + 2});
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    cam_data = '0;
    if (deliver) begin
      if (nbytes >= 2) m_y++;
      if ((nbytes / 2 != H) || (nbytes % 2 != 0)) m_err = 1'b1;
    end
    repeat (4) @(negedge cam_pclk);
  endtask

  task automatic send_frame(input int len[4], input int nlines, input int drop_after = -1);
    bit deliver;
    deliver = (skip_left == 0);
    m_y = 0;
    for (int l = 0; l < nlines; l++) begin
      send_line(len[l], deliver);
      if (l == drop_after) begin
        cam_init_done = 1'b0;
        deliver   = 1'b0;
        skip_left = 99;
        m_err     = 1'b0;
        repeat (3) @(negedge cam_pclk);
        check("init_drop_state", dut.state_q, WAIT_INIT);
      end
    end
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    if (deliver && m_y > 0) begin
      done_q.push_back(m_err || (m_y != V));
      m_err = 1'b0;
    end
    if (skip_left > 0) skip_left--;
    repeat (3) @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge cam_pclk);
  endtask

  initial begin
    int len[4];
    int nl;

    repeat (3) @(negedge cam_pclk);
    check_all_zero("reset");
    rst = 1'b0;
    start_init();

    // Two discarded frames, then a delivered 4x2 frame whose first pixel is F8,1F.
    send_frame('{8, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);
    use_f81f = 1'b1;
    send_frame('{8, 8, 0, 0}, 2);
    use_f81f = 1'b0;

    // Short line, then a correct frame, then an odd byte count.
    send_frame('{6, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);
    send_frame('{7, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);

    // Randomised geometry.
    for (int f = 0; f < 10; f++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < 4; l++)
        len[l] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 8;
      send_frame(len, nl);
    end

    // Config lost between lines of a running frame, then re-established.
    send_frame('{8, 8, 0, 0}, 2, 0);
    start_init();
    send_frame('{8, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);

    // Asynchronous reset in the middle of a line, before any pixel completes.
    @(negedge cam_pclk); cam_href = 1'b1; cam_data = 8'hA5;
    @(negedge cam_pclk); cam_data = 8'h5A;
    @(negedge cam_pclk); cam_data = 8'h3C;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge cam_pclk); cam_href = 1'b0; cam_data = '0;
    @(negedge cam_pclk); rst = 1'b0;
    skip_left = 99;
    m_err     = 1'b0;
    repeat (5) @(negedge cam_pclk);
    skip_left = WF;
    send_frame('{8, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);
    send_frame('{8, 8, 0, 0}, 2);

    repeat (10) @(negedge cam_pclk);
    check("pix_queue_drained", pix_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
